hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Central stall/flush sequencer for the RV32IM 5-stage pipeline. It drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables, the PC enable, and the flush/bubble controls. It resolves load-use hazards, branch/jump redirects from EX, data-memory busywait, and multi-cycle M-extension operations in EX. It runs a small FSM for the mul/div handshake and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Clock and reset: one clock; reset is synchronous and active-high, on ports `CLK` and `RESET`.

Parameters:
- `MULDIV_TIMEOUT`, default 40: maximum cycles in MULDIV_BUSY before watchdog release.
- `STALL_CNT_W`, default 32: width of the stall counter.

Ports:
- `CLK` in 1: clock.
- `RESET` in 1: synchronous, active-high reset.
- `MEM_BUSYWAIT` in 1: data memory not ready; the whole pipeline freezes.
- `MEM_READ_EN_IDEX` in 1: the instruction in EX is a load.
- `REG_WRITE_ADDR_IDEX` in 5: rd of the instruction in EX.
- `ADDR_1_IFID`, `ADDR_2_IFID` in 5 each: rs1/rs2 of the instruction in ID.
- `USES_RS1_IFID`, `USES_RS2_IFID` in 1 each: ID instruction actually reads rs1/rs2.
- `BRANCH_SEL` in 1: taken branch or jump resolved in EX.
- `MULDIV_START_IDEX` in 1: the instruction in EX is MUL/DIV/REM.
- `MULDIV_DONE` in 1: single-cycle pulse from the mul/div unit; result valid.
- `PC_EN`, `IFID_EN`, `IDEX_EN`, `EXMEM_EN`, `MEMWB_EN` out 1 each: register load enables.
- `IFID_FLUSH`, `IDEX_FLUSH` out 1 each: load a NOP on the next edge.
- `EXMEM_BUBBLE` out 1: EX/MEM captures a NOP instead of the EX result.
- `MULDIV_GO` out 1: single-cycle start pulse to the mul/div unit.
- `MULDIV_ERR` out 1: sticky watchdog error.
- `STALL_CYCLES` out `STALL_CNT_W`: saturating count of cycles with `PC_EN`=0.

## Operation
- FSM states: RUN and MULDIV_BUSY. Other registers: `done_pending`, the watchdog counter `wd_cnt`, `MULDIV_ERR`, and `STALL_CYCLES`.
- Outputs are combinational from state, inputs and `done_pending`. Evaluate the rules below in priority order; the first match applies.
  1. `RESET`=1:
     - all `*_EN`=0, both flushes=1, `EXMEM_BUBBLE`=0, `MULDIV_GO`=0.
     - Next edge: state=RUN, counters=0, `MULDIV_ERR`=0, `done_pending`=0.
  2. `MEM_BUSYWAIT`=1:
     - all enables 0, no flush, no bubble, `MULDIV_GO`=0; state held.
     - In MULDIV_BUSY, a `MULDIV_DONE` arriving now sets `done_pending`, and `wd_cnt` keeps counting.
  3. MULDIV_BUSY with `MULDIV_DONE` or `done_pending` set:
     - all enables 1, `EXMEM_BUBBLE`=0, so EX/MEM captures the result.
     - Next: state=RUN, `done_pending`=0, `wd_cnt`=0.
  4. MULDIV_BUSY with `wd_cnt`=`MULDIV_TIMEOUT`-1:
     - same release as rule 3, and `MULDIV_ERR` is set; it stays set until reset.
  5. MULDIV_BUSY otherwise:
     - `PC_EN`=`IFID_EN`=`IDEX_EN`=0, `EXMEM_EN`=`MEMWB_EN`=1, `EXMEM_BUBBLE`=1.
     - `wd_cnt` increments. `BRANCH_SEL` is ignored.
  6. RUN with `BRANCH_SEL`=1:
     - all enables 1, `IFID_FLUSH`=`IDEX_FLUSH`=1.
     - Branch beats load-use because the ID instruction is wrong-path.
  7. RUN with `MULDIV_START_IDEX`=1:
     - `MULDIV_GO`=1 for this cycle only; stalls as in rule 5.
     - Next: state=MULDIV_BUSY, `wd_cnt`=1.
  8. RUN with load-use hazard:
     - Hazard = `MEM_READ_EN_IDEX` && rd≠0 && ((`USES_RS1_IFID` && rs1==rd) || (`USES_RS2_IFID` && rs2==rd)).
     - `PC_EN`=`IFID_EN`=0, `IDEX_FLUSH`=1, other enables 1.
  9. RUN otherwise: all enables 1, no flush, no bubble.
- `STALL_CYCLES` increments on every non-reset cycle with `PC_EN`=0 and saturates at all-ones.

## Timing
- Reset values: state RUN, `MULDIV_ERR`=0, `STALL_CYCLES`=0, `done_pending`=0. Combinational outputs while `RESET` is high are as given in rule 1.
- Load-use costs exactly 1 bubble cycle; branch costs 2 flushed slots.
- Mul/div, with `MULDIV_DONE` arriving k cycles after `MULDIV_GO`: front end stalled for k cycles (the GO cycle and k-1 in BUSY); release happens in the DONE cycle.
- `MULDIV_GO` is never reasserted for the same instruction. It is suppressed under `MEM_BUSYWAIT` and retried once busywait drops.
- `MULDIV_DONE` in the GO cycle is ignored; the mul/div unit guarantees latency ≥1.
- A branch coinciding with `MEM_BUSYWAIT` is deferred. EX is frozen, so `BRANCH_SEL` persists and the flush occurs on the first non-busy cycle.

## Structure
- Shared package `pipeline_ctrl_pkg` holds the state encoding constants (`ST_RUN`=1'b0, `ST_MULDIV_BUSY`=1'b1).
- One sub-module, `load_use_detector`: purely combinational, implements the rule 8 equation.

## Test plan
- Load `x5` in EX and `add x6,x5,x1` in ID → one cycle with `PC_EN`=0, `IFID_EN`=0, `IDEX_FLUSH`=1; `STALL_CYCLES` becomes 1.
- Load `x0` in EX with rs1=0 in ID → no stall.
- `BRANCH_SEL`=1 together with a load-use hazard → both flushes =1, `PC_EN`=1, no stall.
- `MULDIV_START_IDEX` with DONE 4 cycles later:
  - `MULDIV_GO` high for one cycle; 4 cycles of `EXMEM_BUBBLE`=1; release on the DONE cycle.
  - `STALL_CYCLES`=4.
- DONE pulse during `MEM_BUSYWAIT` in MULDIV_BUSY → `done_pending` is set; release occurs in the first cycle busywait is low.
- No DONE → release at cycle 40 after GO; `MULDIV_ERR`=1 and held until `RESET`.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   - FSM state encoding for the mul/div handshake sequencer.
//   - ctrl_t: the bundle of enable/flush/bubble/start controls that the
//     hazard unit drives each cycle, plus named constant patterns for the
//     common cases so the top-level priority chain reads as a table.
package pipeline_ctrl_pkg;

    localparam logic [0:0] ST_RUN         = 1'b0;
    localparam logic [0:0] ST_MULDIV_BUSY = 1'b1;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_bubble;
        logic muldiv_go;
    } ctrl_t;

    // Everything advances, nothing squashed.
    localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // Held in reset: no register loads, both front-end slots forced to NOP.
    localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    // Data memory busy: the whole pipeline holds its contents.
    localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Mul/div in flight: front end and EX hold, MEM/WB drain behind a bubble.
    localparam ctrl_t CTRL_MD_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    // Redirect from EX: the two younger instructions are wrong-path.
    localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Load-use: hold PC and IF/ID, send one bubble into EX.
    localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector.
// Flags when the instruction in EX is a load whose destination (non-x0)
// is a source register actually read by the instruction in ID.
// Ports:
//   mem_read_i         - EX instruction is a load
//   rd_i               - destination register of the EX instruction
//   rs1_i / rs2_i      - source registers of the ID instruction
//   uses_rs1_i/rs2_i   - ID instruction really reads rs1 / rs2
//   hazard_o           - stall ID for one cycle
module load_use_detector (
    input  logic       mem_read_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       uses_rs1_i,
    input  logic       uses_rs2_i,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = uses_rs1_i && (rs1_i == rd_i);
    assign rs2_hit  = uses_rs2_i && (rs2_i == rd_i);
    // x0 is never written, so a load to x0 cannot create a dependency.
    assign hazard_o = mem_read_i && (rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central stall/flush sequencer for the 5-stage RV32IM pipeline.
// Resolves, in priority order: reset, data-memory busywait, an in-flight
// mul/div (done / pending done / watchdog / wait), a branch redirect from
// EX, a mul/div start in EX, and a load-use hazard.
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   MEM_BUSYWAIT          - data memory not ready, freeze everything
//   MEM_READ_EN_IDEX, REG_WRITE_ADDR_IDEX - load flag and rd of EX instr
//   ADDR_1/2_IFID, USES_RS1/2_IFID        - sources of ID instr
//   BRANCH_SEL            - taken branch/jump resolved in EX
//   MULDIV_START_IDEX     - EX instr is MUL/DIV/REM
//   MULDIV_DONE           - one-cycle result-valid pulse from mul/div unit
//   *_EN                  - pipeline register / PC load enables
//   IFID_FLUSH, IDEX_FLUSH, EXMEM_BUBBLE - NOP insertion controls
//   MULDIV_GO             - one-cycle start pulse to the mul/div unit
//   MULDIV_ERR            - sticky watchdog error
//   STALL_CYCLES          - saturating count of cycles with PC_EN low
module hazard_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = 40,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   MEM_BUSYWAIT,
    input  logic                   MEM_READ_EN_IDEX,
    input  logic [4:0]             REG_WRITE_ADDR_IDEX,
    input  logic [4:0]             ADDR_1_IFID,
    input  logic [4:0]             ADDR_2_IFID,
    input  logic                   USES_RS1_IFID,
    input  logic                   USES_RS2_IFID,
    input  logic                   BRANCH_SEL,
    input  logic                   MULDIV_START_IDEX,
    input  logic                   MULDIV_DONE,
    output logic                   PC_EN,
    output logic                   IFID_EN,
    output logic                   IDEX_EN,
    output logic                   EXMEM_EN,
    output logic                   MEMWB_EN,
    output logic                   IFID_FLUSH,
    output logic                   IDEX_FLUSH,
    output logic                   EXMEM_BUBBLE,
    output logic                   MULDIV_GO,
    output logic                   MULDIV_ERR,
    output logic [STALL_CNT_W-1:0] STALL_CYCLES
);

    localparam int           WD_W     = $clog2(MULDIV_TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MULDIV_TIMEOUT - 1);

    logic [0:0]             state_q, state_d;
    logic                   done_pending_q, done_pending_d;
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                   err_q, err_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   load_use;
    logic                   done_seen;
    ctrl_t                  ctrl;

    load_use_detector u_load_use (
        .mem_read_i (MEM_READ_EN_IDEX),
        .rd_i       (REG_WRITE_ADDR_IDEX),
        .rs1_i      (ADDR_1_IFID),
        .rs2_i      (ADDR_2_IFID),
        .uses_rs1_i (USES_RS1_IFID),
        .uses_rs2_i (USES_RS2_IFID),
        .hazard_o   (load_use)
    );

    assign done_seen = MULDIV_DONE || done_pending_q;

    always_comb begin
        ctrl           = CTRL_RUN;
        state_d        = state_q;
        done_pending_d = done_pending_q;
        wd_cnt_d       = wd_cnt_q;
        err_d          = err_q;

        if (RESET) begin
            ctrl           = CTRL_RESET;
            state_d        = ST_RUN;
            done_pending_d = 1'b0;
            wd_cnt_d       = '0;
            err_d          = 1'b0;
        end else if (MEM_BUSYWAIT) begin
            ctrl = CTRL_FREEZE;
            if (state_q == ST_MULDIV_BUSY) begin
                // The DONE pulse cannot be consumed while frozen; remember it.
                if (MULDIV_DONE) begin
                    done_pending_d = 1'b1;
                end
                // Keep timing, but park at the limit so the watchdog still
                // fires on the first non-busy cycle.
                if (wd_cnt_q != WD_LIMIT) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
        end else if (state_q == ST_MULDIV_BUSY) begin
            if (done_seen || (wd_cnt_q == WD_LIMIT)) begin
                ctrl           = CTRL_RUN;
                state_d        = ST_RUN;
                done_pending_d = 1'b0;
                wd_cnt_d       = '0;
                if (!done_seen) begin
                    err_d = 1'b1;
                end
            end else begin
                ctrl     = CTRL_MD_STALL;
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end else if (BRANCH_SEL) begin
            ctrl = CTRL_BRANCH;
        end else if (MULDIV_START_IDEX) begin
            ctrl           = CTRL_MD_STALL;
            ctrl.muldiv_go = 1'b1;
            state_d        = ST_MULDIV_BUSY;
            wd_cnt_d       = WD_W'(1);
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!ctrl.pc_en && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_RUN;
            done_pending_q <= 1'b0;
            wd_cnt_q       <= '0;
            err_q          <= 1'b0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            done_pending_q <= done_pending_d;
            wd_cnt_q       <= wd_cnt_d;
            err_q          <= err_d;
            stall_q        <= stall_d;
        end
    end

    assign PC_EN        = ctrl.pc_en;
    assign IFID_EN      = ctrl.ifid_en;
    assign IDEX_EN      = ctrl.idex_en;
    assign EXMEM_EN     = ctrl.exmem_en;
    assign MEMWB_EN     = ctrl.memwb_en;
    assign IFID_FLUSH   = ctrl.ifid_flush;
    assign IDEX_FLUSH   = ctrl.idex_flush;
    assign EXMEM_BUBBLE = ctrl.exmem_bubble;
    assign MULDIV_GO    = ctrl.muldiv_go;
    assign MULDIV_ERR   = err_q;
    assign STALL_CYCLES = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// priority rules kept in this file.
module tb_hazard_ctrl_unit;

    localparam int TIMEOUT = 40;
    localparam longint STALL_MAX = 64'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_BUSYWAIT;
    logic        MEM_READ_EN_IDEX;
    logic [4:0]  REG_WRITE_ADDR_IDEX;
    logic [4:0]  ADDR_1_IFID;
    logic [4:0]  ADDR_2_IFID;
    logic        USES_RS1_IFID;
    logic        USES_RS2_IFID;
    logic        BRANCH_SEL;
    logic        MULDIV_START_IDEX;
    logic        MULDIV_DONE;
    logic        PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN;
    logic        IFID_FLUSH, IDEX_FLUSH, EXMEM_BUBBLE, MULDIV_GO, MULDIV_ERR;
    logic [31:0] STALL_CYCLES;

    always #5 CLK = ~CLK;

    hazard_ctrl_unit #(.MULDIV_TIMEOUT(TIMEOUT), .STALL_CNT_W(32)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .MEM_BUSYWAIT        (MEM_BUSYWAIT),
        .MEM_READ_EN_IDEX    (MEM_READ_EN_IDEX),
        .REG_WRITE_ADDR_IDEX (REG_WRITE_ADDR_IDEX),
        .ADDR_1_IFID         (ADDR_1_IFID),
        .ADDR_2_IFID         (ADDR_2_IFID),
        .USES_RS1_IFID       (USES_RS1_IFID),
        .USES_RS2_IFID       (USES_RS2_IFID),
        .BRANCH_SEL          (BRANCH_SEL),
        .MULDIV_START_IDEX   (MULDIV_START_IDEX),
        .MULDIV_DONE         (MULDIV_DONE),
        .PC_EN               (PC_EN),
        .IFID_EN             (IFID_EN),
        .IDEX_EN             (IDEX_EN),
        .EXMEM_EN            (EXMEM_EN),
        .MEMWB_EN            (MEMWB_EN),
        .IFID_FLUSH          (IFID_FLUSH),
        .IDEX_FLUSH          (IDEX_FLUSH),
        .EXMEM_BUBBLE        (EXMEM_BUBBLE),
        .MULDIV_GO           (MULDIV_GO),
        .MULDIV_ERR          (MULDIV_ERR),
        .STALL_CYCLES        (STALL_CYCLES)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: whether a mul/div is outstanding, how many cycles
    // have elapsed since its GO, whether its DONE was seen while frozen,
    // the sticky error, and the stall tally.
    bit     m_busy;
    bit     m_pend;
    bit     m_err;
    int     m_elapsed;
    longint m_stalls;

    // One clock cycle: check combinational controls for the inputs currently
    // applied, advance the model, then check the registered outputs.
    task automatic step();
        bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_flif, e_flid, e_bub, e_go;
        bit hz, n_busy, n_pend, n_err;
        int n_elapsed;
        #2;
        hz = MEM_READ_EN_IDEX && (REG_WRITE_ADDR_IDEX != 0) &&
             ((USES_RS1_IFID && (ADDR_1_IFID == REG_WRITE_ADDR_IDEX)) ||
              (USES_RS2_IFID && (ADDR_2_IFID == REG_WRITE_ADDR_IDEX)));
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        {e_flif, e_flid, e_bub, e_go} = 4'b0000;
        n_busy = m_busy; n_pend = m_pend; n_err = m_err; n_elapsed = m_elapsed;

        if (RESET) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
            e_flif = 1; e_flid = 1;
            n_busy = 0; n_pend = 0; n_err = 0; n_elapsed = 0;
        end else if (MEM_BUSYWAIT) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
            if (m_busy) begin
                if (MULDIV_DONE) n_pend = 1;
                n_elapsed = (m_elapsed + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : m_elapsed + 1;
            end
        end else if (m_busy && (MULDIV_DONE || m_pend)) begin
            n_busy = 0; n_pend = 0; n_elapsed = 0;
        end else if (m_busy && (m_elapsed == TIMEOUT - 1)) begin
            n_busy = 0; n_pend = 0; n_elapsed = 0; n_err = 1;
        end else if (m_busy) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_bub = 1;
            n_elapsed = m_elapsed + 1;
        end else if (BRANCH_SEL) begin
            e_flif = 1; e_flid = 1;
        end else if (MULDIV_START_IDEX) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_bub = 1; e_go = 1;
            n_busy = 1; n_elapsed = 1;
        end else if (hz) begin
            e_pc = 0; e_ifid = 0; e_flid = 1;
        end

        check_eq("ctrl", {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN,
                          IFID_FLUSH, IDEX_FLUSH, EXMEM_BUBBLE, MULDIV_GO},
                 {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_flif, e_flid, e_bub, e_go});

        if (RESET) m_stalls = 0;
        else if (!e_pc && m_stalls < STALL_MAX) m_stalls++;
        m_busy = n_busy; m_pend = n_pend; m_err = n_err; m_elapsed = n_elapsed;

        @(posedge CLK);
        #1;
        check_eq("err", MULDIV_ERR, m_err);
        check_eq("stalls", STALL_CYCLES, m_stalls);
    endtask

    task automatic set_idle();
        RESET = 0; MEM_BUSYWAIT = 0; MEM_READ_EN_IDEX = 0; REG_WRITE_ADDR_IDEX = 0;
        ADDR_1_IFID = 0; ADDR_2_IFID = 0; USES_RS1_IFID = 0; USES_RS2_IFID = 0;
        BRANCH_SEL = 0; MULDIV_START_IDEX = 0; MULDIV_DONE = 0;
    endtask

    task automatic do_reset();
        set_idle();
        RESET = 1;
        step();
        step();
        RESET = 0;
    endtask

    initial begin
        bit drought;
        m_busy = 0; m_pend = 0; m_err = 0; m_elapsed = 0; m_stalls = 0;

        // Reset state
        do_reset();
        check_eq("rst_err", MULDIV_ERR, 0);
        check_eq("rst_stalls", STALL_CYCLES, 0);

        // Load x5 in EX, add x6,x5,x1 in ID: one bubble
        MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 5;
        ADDR_1_IFID = 5; ADDR_2_IFID = 1; USES_RS1_IFID = 1; USES_RS2_IFID = 1;
        step();
        check_eq("lu_stall_cnt", STALL_CYCLES, 1);
        set_idle();
        step();

        // Load to x0 never stalls
        MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 0; ADDR_1_IFID = 0; USES_RS1_IFID = 1;
        step();
        check_eq("x0_no_stall", STALL_CYCLES, 1);

        // Branch beats load-use
        set_idle();
        MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 7; ADDR_2_IFID = 7; USES_RS2_IFID = 1;
        BRANCH_SEL = 1;
        step();
        check_eq("br_no_stall", STALL_CYCLES, 1);

        // Mul/div with DONE four cycles after GO
        do_reset();
        MULDIV_START_IDEX = 1;
        repeat (4) step();
        MULDIV_DONE = 1;
        step();
        MULDIV_DONE = 0; MULDIV_START_IDEX = 0;
        check_eq("md_stall_cnt", STALL_CYCLES, 4);
        step();

        // DONE arrives while frozen; release on first non-busy cycle
        do_reset();
        MULDIV_START_IDEX = 1;
        step();
        step();
        MEM_BUSYWAIT = 1; MULDIV_DONE = 1;
        step();
        MULDIV_DONE = 0;
        step();
        MEM_BUSYWAIT = 0;
        step();
        MULDIV_START_IDEX = 0;
        check_eq("pend_stall_cnt", STALL_CYCLES, 4);
        check_eq("pend_no_err", MULDIV_ERR, 0);
        step();

        // No DONE: watchdog releases on the 40th cycle counting GO
        do_reset();
        MULDIV_START_IDEX = 1;
        repeat (TIMEOUT) step();
        MULDIV_START_IDEX = 0;
        check_eq("wd_err_set", MULDIV_ERR, 1);
        check_eq("wd_stall_cnt", STALL_CYCLES, TIMEOUT - 1);
        repeat (5) step();
        check_eq("wd_err_sticky", MULDIV_ERR, 1);
        do_reset();
        check_eq("wd_err_cleared", MULDIV_ERR, 0);

        // Randomized traffic
        drought = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) == 0) drought = ~drought;
            RESET               = ($urandom_range(0, 199) == 0);
            MEM_BUSYWAIT        = ($urandom_range(0, 4) == 0);
            MEM_READ_EN_IDEX    = $urandom_range(0, 1);
            REG_WRITE_ADDR_IDEX = 5'($urandom_range(0, 3));
            ADDR_1_IFID         = 5'($urandom_range(0, 3));
            ADDR_2_IFID         = 5'($urandom_range(0, 3));
            USES_RS1_IFID       = $urandom_range(0, 1);
            USES_RS2_IFID       = $urandom_range(0, 1);
            BRANCH_SEL          = ($urandom_range(0, 6) == 0);
            MULDIV_START_IDEX   = ($urandom_range(0, 5) == 0);
            MULDIV_DONE         = !drought && ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
